aes_decipher_sched: RTL and testbench
=====================================

// Module: aes_decipher_sched
// PURPOSE
//  Stream-level sequencer for the iterative AES decipher round block. Accepts
//  ciphertext blocks on a valid/ready input and pulses the round block's next.
//  Waits for its ready handshake, then presents plaintext on a valid/ready output.
//  Performs CBC chaining (XOR with previous ciphertext/IV) when enabled.
//  Sits between the bus/DMA front end and the decipher round block; key expansion is separate.
// PARAMETERS
//  CBC_SUPPORT  1  1: cbc_en honoured; 0: chaining XOR removed, always ECB
// PORTS
//  clk            in   1    clock
//  reset_n        in   1    reset, asynchronous, active-low
//  keylen         in   1    0=AES-128, 1=AES-256; sampled at block acceptance
//  key_ready      in   1    round keys expanded and valid
//  cbc_en         in   1    1=CBC decrypt, 0=ECB; sampled at block acceptance
//  iv             in   128  initial chaining value
//  iv_load        in   1    load iv into chain register (honoured in IDLE only)
//  in_valid       in   1    ciphertext block valid
//  in_ready       out  1    ciphertext block accepted when in_valid&in_ready
//  in_block       in   128  ciphertext block
//  out_valid      out  1    plaintext block valid
//  out_ready      in   1    downstream accepts plaintext
//  out_block      out  128  plaintext block
//  busy           out  1    high in any state other than IDLE
//  blk_cnt        out  32   completed output handshakes, wraps 0xFFFFFFFF->0
//  dec_next       out  1    one-cycle start pulse to round block
//  dec_keylen     out  1    latched keylen to round block / key memory
//  dec_block      out  128  latched ciphertext to round block
//  dec_ready      in   1    round block idle/done
//  dec_new_block  in   128  round block result
// BEHAVIOUR
//  Reset: state IDLE; out_valid=0, out_block=0, dec_next=0, dec_keylen=0, dec_block=0,
//   chain_reg=0, busy=0, blk_cnt=0; in_ready=0 while reset_n low.
//  in_ready = (state==IDLE) & key_ready & !iv_load (combinational).
//  FSM:
//   IDLE: on iv_load, chain_reg<=iv and the state stays IDLE. On in_valid&in_ready,
//    dec_block<=in_block, dec_keylen<=keylen, mode_reg<=cbc_en&CBC_SUPPORT, -> START.
//   START: dec_next=1 for exactly this cycle -> ACK.
//   ACK: wait dec_ready==0 (round block started) -> RUN.
//   RUN: on dec_ready==1: out_block<=dec_new_block^(mode_reg?chain_reg:0), out_valid<=1, -> OUT.
//   OUT: hold out_block/out_valid stable until out_valid&out_ready. At that handshake:
//    out_valid<=0; chain_reg<=dec_block if mode_reg; blk_cnt+=1; -> IDLE.
//  Latency: accept at edge T -> dec_next high in cycle T+1.
//   out_valid rises 1 cycle after dec_ready is sampled high in RUN.
//   Min throughput gap: one IDLE cycle between output handshake and next acceptance.
//  dec_block/dec_keylen are stable from START until return to IDLE.
//  Boundary cases:
//   - iv_load with in_valid in IDLE: IV load wins; no acceptance that cycle.
//   - iv_load outside IDLE: ignored.
//   - key_ready is checked only at acceptance; deassertion mid-operation does not abort.
//   - keylen/cbc_en changes mid-operation have no effect until the next block.
//   - ECB mode leaves chain_reg unchanged.
//   - out_ready held low: the FSM stalls in OUT indefinitely with no data loss.
//   - reset_n low mid-operation: immediate return to reset values; chain_reg lost.
//     The IV must be reloaded before CBC.
//   - blk_cnt wraps modulo 2^32 with no flag.
// TESTING
//  1 ECB AES-128, key 000102..0f, in 69c4e0d86a7b0430d8cdb78070b4c55a
//    -> out 00112233445566778899aabbccddeeff, blk_cnt=1.
//  2 ECB AES-256, key 000102..1f, in 8ea2b7ca516745bfeafc49904b496089
//    -> out 00112233445566778899aabbccddeeff.
//  3 CBC AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102..0f:
//    in 7649abac8119b246cee98e9b12e9197d -> 6bc1bee22e409f96e93d7e117393172a;
//    in 5086cb9b507219ee95db113a917678b2 -> ae2d8a571e03ac9c9eb76fac45af8e51.
//  4 Hold out_ready=0 for 20 cycles in OUT -> out_valid and out_block stable,
//    in_ready=0, and dec_next not re-pulsed.
//  5 iv_load=1 with in_valid=1 in IDLE -> in_ready=0 that cycle, IV loaded;
//    the block is accepted next cycle and its CBC output uses the new IV.
//  6 reset_n low during RUN -> all outputs at reset values.
//    After release, the key_ready=0 case gives in_ready=0.
//    With key_ready=1 the next block decrypts correctly.

Source files
------------

// File: rtl/aes_decipher_sched.sv
// Stream sequencer for the iterative AES decipher round block: accepts ciphertext,
// starts the round block, and returns plaintext with optional CBC chaining.
module aes_decipher_sched #(
  parameter int CBC_SUPPORT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         keylen,
  input  logic         key_ready,
  input  logic         cbc_en,
  input  logic [127:0] iv,
  input  logic         iv_load,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [31:0]  blk_cnt,
  output logic         dec_next,
  output logic         dec_keylen,
  output logic [127:0] dec_block,
  input  logic         dec_ready,
  input  logic [127:0] dec_new_block
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ACK,
    S_RUN,
    S_OUT
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] chain_q, chain_d;
  logic [127:0] dec_block_q, dec_block_d;
  logic [127:0] out_block_q, out_block_d;
  logic         mode_q, mode_d;
  logic         dec_keylen_q, dec_keylen_d;
  logic         out_valid_q, out_valid_d;
  logic         dec_next_q, dec_next_d;
  logic [31:0]  blk_cnt_q, blk_cnt_d;
  logic         accept;

  // An IV load in IDLE takes priority over accepting a block in the same cycle.
  assign in_ready = reset_n & (state_q == S_IDLE) & key_ready & ~iv_load;
  assign accept   = in_valid & in_ready;

  assign out_valid  = out_valid_q;
  assign out_block  = out_block_q;
  assign busy       = (state_q != S_IDLE);
  assign blk_cnt    = blk_cnt_q;
  assign dec_next   = dec_next_q;
  assign dec_keylen = dec_keylen_q;
  assign dec_block  = dec_block_q;

  always_comb begin
    state_d      = state_q;
    chain_d      = chain_q;
    dec_block_d  = dec_block_q;
    out_block_d  = out_block_q;
    mode_d       = mode_q;
    dec_keylen_d = dec_keylen_q;
    out_valid_d  = out_valid_q;
    dec_next_d   = 1'b0;
    blk_cnt_d    = blk_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (iv_load) begin
          chain_d = iv;
        end else if (accept) begin
          dec_block_d  = in_block;
          dec_keylen_d = keylen;
          mode_d       = cbc_en & (CBC_SUPPORT != 0);
          dec_next_d   = 1'b1;
          state_d      = S_START;
        end
      end
      S_START: state_d = S_ACK;
      // The round block drops ready once it has taken the start pulse.
      S_ACK: begin
        if (!dec_ready) state_d = S_RUN;
      end
      S_RUN: begin
        if (dec_ready) begin
          out_block_d = dec_new_block ^ (mode_q ? chain_q : 128'd0);
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (mode_q) chain_d = dec_block_q;
          blk_cnt_d   = blk_cnt_q + 32'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      chain_q      <= '0;
      dec_block_q  <= '0;
      out_block_q  <= '0;
      mode_q       <= 1'b0;
      dec_keylen_q <= 1'b0;
      out_valid_q  <= 1'b0;
      dec_next_q   <= 1'b0;
      blk_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      chain_q      <= chain_d;
      dec_block_q  <= dec_block_d;
      out_block_q  <= out_block_d;
      mode_q       <= mode_d;
      dec_keylen_q <= dec_keylen_d;
      out_valid_q  <= out_valid_d;
      dec_next_q   <= dec_next_d;
      blk_cnt_q    <= blk_cnt_d;
    end
  end

endmodule

// File: tb/tb_aes_decipher_sched.sv
// Bench for aes_decipher_sched: a behavioural round-block stand-in plus a
// transaction-level scoreboard checked every cycle, with known-answer vectors.
module tb_aes_decipher_sched;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         keylen = 1'b0, key_ready = 1'b1, cbc_en = 1'b0, iv_load = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b1, dec_ready = 1'b1;
  logic [127:0] iv = '0, in_block = '0, dec_new_block = '0;
  logic         in_ready, out_valid, busy, dec_next, dec_keylen;
  logic [127:0] out_block, dec_block;
  logic [31:0]  blk_cnt;

  int errors = 0;
  int checks = 0;

  aes_decipher_sched #(.CBC_SUPPORT(1)) dut (
    .clk(clk), .reset_n(reset_n), .keylen(keylen), .key_ready(key_ready),
    .cbc_en(cbc_en), .iv(iv), .iv_load(iv_load), .in_valid(in_valid),
    .in_ready(in_ready), .in_block(in_block), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy), .blk_cnt(blk_cnt),
    .dec_next(dec_next), .dec_keylen(dec_keylen), .dec_block(dec_block),
    .dec_ready(dec_ready), .dec_new_block(dec_new_block)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CBC_C1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC_C2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CBC_P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CBC_P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] IV_STD  = 128'h000102030405060708090a0b0c0d0e0f;

  // Raw AES decryption results (before chaining) for the known vectors; any other
  // block gets an arbitrary but deterministic stand-in transform.
  function automatic logic [127:0] rb_fn(input logic [127:0] b, input logic kl);
    if (!kl && b == CT_128) return PT_FIPS;
    if ( kl && b == CT_256) return PT_FIPS;
    if (!kl && b == CBC_C1) return 128'h6bc0bce12a459991e134741a7f9e1925;
    if (!kl && b == CBC_C2) return 128'hd86421fb9f1a1eda505ee1375746972c;
    return {b[63:0], b[127:64]} ^ (kl ? {4{32'ha5a55a5a}} : {4{32'h3c3cc3c3}});
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard state
  logic         m_busy = 0, m_next_due = 0, m_ov = 0, m_mode = 0, m_kl = 0;
  logic [31:0]  m_cnt = 0;
  logic [127:0] m_chain = '0, m_ct = '0, m_exp_out = '0;
  logic         rb_fresh = 0;
  int           rb_gen = 0;

  // Round block stand-in: takes the start pulse, drops ready, later returns the result.
  initial begin
    logic [127:0] b;
    logic         k;
    int           g, lat;
    forever begin
      @(negedge clk);
      if (dec_next && reset_n) begin
        b = dec_block; k = dec_keylen; g = rb_gen;
        @(posedge clk); #1;
        dec_ready = 1'b0;
        dec_new_block = {$urandom, $urandom, $urandom, $urandom};
        lat = $urandom_range(1, 6);
        repeat (lat) @(posedge clk);
        #1;
        dec_new_block = rb_fn(b, k);
        dec_ready = 1'b1;
        if (g == rb_gen) rb_fresh = 1'b1;
      end
    end
  end

  // Per-cycle compare, then advance the scoreboard to the next clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_block", out_block, 0);
        chk("rst_dec_next", dec_next, 0);
        chk("rst_dec_keylen", dec_keylen, 0);
        chk("rst_dec_block", dec_block, 0);
        chk("rst_busy", busy, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        m_busy = 0; m_next_due = 0; m_ov = 0; m_cnt = 0; m_chain = '0;
        rb_fresh = 0; rb_gen++;
      end else begin
        chk("in_ready", in_ready, !m_busy && key_ready && !iv_load);
        chk("busy", busy, m_busy);
        chk("blk_cnt", blk_cnt, m_cnt);
        chk("dec_next", dec_next, m_next_due);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) chk("out_block", out_block, m_exp_out);
        if (m_busy) begin
          chk("dec_block", dec_block, m_ct);
          chk("dec_keylen", dec_keylen, m_kl);
        end
        m_next_due = 0;
        if (!m_busy) begin
          if (iv_load) m_chain = iv;
          else if (in_valid && key_ready) begin
            m_busy = 1; m_next_due = 1;
            m_ct = in_block; m_kl = keylen; m_mode = cbc_en;
            m_exp_out = rb_fn(in_block, keylen) ^ (cbc_en ? m_chain : 128'd0);
          end
        end else if (m_ov) begin
          if (out_ready) begin
            m_ov = 0; m_busy = 0; m_cnt = m_cnt + 1;
            if (m_mode) m_chain = m_ct;
          end
        end else if (rb_fresh) begin
          rb_fresh = 0; m_ov = 1;
        end
      end
    end
  end

  task automatic wait_accept(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL %s_accept_timeout: in_ready=%0b after %0d cycles, required 1", nm, in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    keylen = ~keylen; cbc_en = ~cbc_en;
    in_block = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_out(input string nm, input logic [127:0] lit);
    int n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL %s_out_timeout: out_valid=0 after %0d cycles, required 1", nm, n);
    end else chk(nm, out_block, lit);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] ct, input logic kl, input logic cbc,
                      input logic [127:0] lit, input string nm);
    @(posedge clk); #1;
    in_block = ct; keylen = kl; cbc_en = cbc; in_valid = 1'b1;
    wait_accept(nm);
    wait_out(nm, lit);
    wait_idle();
  endtask

  task automatic load_iv(input logic [127:0] v);
    @(posedge clk); #1; iv = v; iv_load = 1'b1;
    @(posedge clk); #1; iv_load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // ECB AES-128 and AES-256 known answers
    send(CT_128, 1'b0, 1'b0, PT_FIPS, "ecb128");
    chk("blk_cnt_after_first", blk_cnt, 1);
    send(CT_256, 1'b1, 1'b0, PT_FIPS, "ecb256");

    // CBC AES-128 two-block chain
    load_iv(IV_STD);
    send(CBC_C1, 1'b0, 1'b1, CBC_P1, "cbc_blk1");
    send(CBC_C2, 1'b0, 1'b1, CBC_P2, "cbc_blk2");

    // Output stall for 20 cycles
    @(posedge clk); #1;
    out_ready = 1'b0; in_block = CT_128; keylen = 1'b0; cbc_en = 1'b0; in_valid = 1'b1;
    wait_accept("stall");
    wait_out("stall_first", PT_FIPS);
    repeat (20) @(negedge clk);
    chk("stall_valid_held", out_valid, 1);
    chk("stall_block_held", out_block, PT_FIPS);
    chk("stall_in_ready", in_ready, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_idle();

    // IV load collides with a valid block: load wins, block accepted next cycle
    load_iv({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    iv = IV_STD; iv_load = 1'b1;
    in_block = CBC_C1; keylen = 1'b0; cbc_en = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    chk("ivload_blocks_accept", in_ready, 0);
    @(posedge clk); #1 iv_load = 1'b0;
    @(negedge clk);
    chk("accept_after_ivload", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out("cbc_new_iv", CBC_P1);
    wait_idle();
    send(CBC_C2, 1'b0, 1'b1, CBC_P2, "cbc_new_iv_blk2");

    // Reset while the round block is running
    @(posedge clk); #1;
    in_block = CT_256; keylen = 1'b1; cbc_en = 1'b0; in_valid = 1'b1;
    wait_accept("rst_mid");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; key_ready = 1'b0; in_valid = 1'b1; in_block = CT_128;
    @(negedge clk);
    chk("no_key_in_ready", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 key_ready = 1'b1;
    // chain register was cleared, so CBC with no IV reload equals ECB here
    send(CT_128, 1'b0, 1'b1, PT_FIPS, "after_reset");
    chk("blk_cnt_after_reset", blk_cnt, 1);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_block  = {$urandom, $urandom, $urandom, $urandom};
      keylen    = $urandom_range(0, 1);
      cbc_en    = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      key_ready = ($urandom_range(0, 7) != 0);
      iv_load   = ($urandom_range(0, 15) == 0);
      iv        = {$urandom, $urandom, $urandom, $urandom};
    end
    @(posedge clk); #1;
    in_valid = 1'b0; iv_load = 1'b0; out_ready = 1'b1; key_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
